// File: rtl/tile_sched_pkg.sv
// Shared types and sizing for the tile scheduler.
// State encoding and tile payload width.
package tile_sched_pkg;

    localparam int N_DEF     = 4;
    localparam int DW_DEF    = 8;
    localparam int IDX_W_DEF = 8;
    localparam int TILE_W    = N_DEF * N_DEF * DW_DEF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    function automatic int tile_bits(input int n, input int dw);
        return n * n * dw;
    endfunction

endpackage

// File: rtl/tile_out_buf.sv
// One-entry valid/ready holding register for result tiles.
// free is high when the entry is empty or drains this cycle.
module tile_out_buf
    import tile_sched_pkg::*;
#(
    parameter int W     = TILE_W,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [W-1:0]     cap_data,
    input  logic [IDX_W-1:0] cap_row,
    input  logic [IDX_W-1:0] cap_col,
    input  logic             cap_last,
    input  logic             out_ready,
    output logic             free,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_row,
    output logic [IDX_W-1:0] out_col,
    output logic             out_last
);

    logic             valid_q, valid_d;
    logic [W-1:0]     data_q, data_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             last_q, last_d;

    assign free = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            valid_d = 1'b1;
            data_d  = cap_data;
            row_d   = cap_row;
            col_d   = cap_col;
            last_d  = cap_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;

endmodule

// File: rtl/tile_scheduler.sv
// Walks a layer's output-tile grid row-major, fetching, launching
// the engine and streaming each result tile through a one-entry buffer.
module tile_scheduler
    import tile_sched_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int DATA_WIDTH = DW_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [IDX_W-1:0]          cmd_m_tiles,
    input  logic [IDX_W-1:0]          cmd_n_tiles,
    input  logic                      cmd_enable_bias,
    input  logic                      cmd_enable_relu,
    input  logic                      cmd_enable_requant,
    input  logic [4:0]                cmd_shift,
    output logic                      fetch_req,
    output logic [IDX_W-1:0]          fetch_row,
    output logic [IDX_W-1:0]          fetch_col,
    input  logic                      fetch_ack,
    output logic                      eng_start,
    input  logic                      eng_done,
    output logic                      eng_enable_bias,
    output logic                      eng_enable_relu,
    output logic                      eng_enable_requant,
    output logic [4:0]                eng_shift,
    input  logic [N*N*DATA_WIDTH-1:0] eng_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*N*DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]          out_row,
    output logic [IDX_W-1:0]          out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      layer_done
);

    localparam int TW = tile_bits(N, DATA_WIDTH);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] m_q, m_d, n_q, n_d;
    logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
    logic             bias_q, bias_d, relu_q, relu_d;
    logic             requant_q, requant_d;
    logic [4:0]       shift_q, shift_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             fetch_req_q, fetch_req_d;
    logic             eng_start_q, eng_start_d;
    logic             busy_q, busy_d;
    logic             capture, buf_free, is_last;

    assign is_last = (row_q == m_q - 1'b1) && (col_q == n_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        bias_d    = bias_q;
        relu_d    = relu_q;
        requant_d = requant_q;
        shift_d   = shift_q;
        capture   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    m_d       = cmd_m_tiles;
                    n_d       = cmd_n_tiles;
                    bias_d    = cmd_enable_bias;
                    relu_d    = cmd_enable_relu;
                    requant_d = cmd_enable_requant;
                    shift_d   = cmd_shift;
                    row_d     = '0;
                    col_d     = '0;
                    if (cmd_m_tiles == '0 || cmd_n_tiles == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (fetch_ack) state_d = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    if (buf_free) capture = 1'b1;
                    else          state_d = S_HOLD;
                end
            end
            // Engine output is frozen here: config latched, no new start.
            S_HOLD: capture = buf_free;
            S_DRAIN: begin
                if (buf_free) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            if (col_q == n_q - 1'b1) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            state_d = is_last ? S_DRAIN : S_FETCH;
        end
        cmd_ready_d = (state_d == S_IDLE);
        fetch_req_d = (state_d == S_FETCH);
        eng_start_d = (state_d == S_LAUNCH);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            n_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            bias_q      <= 1'b0;
            relu_q      <= 1'b0;
            requant_q   <= 1'b0;
            shift_q     <= '0;
            cmd_ready_q <= 1'b1;
            fetch_req_q <= 1'b0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            row_q       <= row_d;
            col_q       <= col_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            requant_q   <= requant_d;
            shift_q     <= shift_d;
            cmd_ready_q <= cmd_ready_d;
            fetch_req_q <= fetch_req_d;
            eng_start_q <= eng_start_d;
            busy_q      <= busy_d;
        end
    end

    tile_out_buf #(
        .W     (TW),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .cap_data  (eng_result),
        .cap_row   (row_q),
        .cap_col   (col_q),
        .cap_last  (is_last),
        .out_ready (out_ready),
        .free      (buf_free),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    assign cmd_ready          = cmd_ready_q;
    assign fetch_req          = fetch_req_q;
    assign fetch_row          = row_q;
    assign fetch_col          = col_q;
    assign eng_start          = eng_start_q;
    assign eng_enable_bias    = bias_q;
    assign eng_enable_relu    = relu_q;
    assign eng_enable_requant = requant_q;
    assign eng_shift          = shift_q;
    assign busy               = busy_q;
    assign layer_done         = (state_q == S_DRAIN) && buf_free;

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomized bench for tile_scheduler with fetch/engine/sink models
// and a row-major expected-tile list.
module tb_tile_scheduler;
    import tile_sched_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int TW = N * N * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [IW-1:0] cmd_m_tiles, cmd_n_tiles;
    logic          cmd_enable_bias, cmd_enable_relu, cmd_enable_requant;
    logic [4:0]    cmd_shift;
    logic          fetch_req, fetch_ack;
    logic [IW-1:0] fetch_row, fetch_col;
    logic          eng_start, eng_done;
    logic          eng_enable_bias, eng_enable_relu, eng_enable_requant;
    logic [4:0]    eng_shift;
    logic [TW-1:0] eng_result;
    logic          out_valid, out_ready, out_last;
    logic [TW-1:0] out_data;
    logic [IW-1:0] out_row, out_col;
    logic          busy, layer_done;

    tile_scheduler #(.N(N), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m_tiles(cmd_m_tiles), .cmd_n_tiles(cmd_n_tiles),
        .cmd_enable_bias(cmd_enable_bias),
        .cmd_enable_relu(cmd_enable_relu),
        .cmd_enable_requant(cmd_enable_requant),
        .cmd_shift(cmd_shift),
        .fetch_req(fetch_req), .fetch_row(fetch_row),
        .fetch_col(fetch_col), .fetch_ack(fetch_ack),
        .eng_start(eng_start), .eng_done(eng_done),
        .eng_enable_bias(eng_enable_bias),
        .eng_enable_relu(eng_enable_relu),
        .eng_enable_requant(eng_enable_requant),
        .eng_shift(eng_shift), .eng_result(eng_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        bit last;
    } tile_t;

    tile_t         exp_q[$];
    int            total = 0;
    int            bad = 0;
    int unsigned   seed;
    int            ntiles, fetch_idx, out_idx, cap_cnt, starts, hs_cnt;
    int            ackd, ack_wait, lat, eng_cnt, rdy_pct, stall_left;
    int            ack_r, ack_c, eng_r, eng_c;
    bit            spur, cmd_pend, cfg_valid, done_seen;
    bit            ack_prev, prev_cap, acc_prev, prev_stall;
    logic [TW-1:0] prev_data;
    logic [7:0]    cfg_word;

    task automatic chk(input string tag, input logic [TW-1:0] got,
                       input logic [TW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] tile_val(input int unsigned s,
                                               input int r, input int c);
        logic [31:0] a;
        a = s ^ (32'(r) * 32'd40503) ^ (32'(c) * 32'd2654435);
        return {a, ~a, a + 32'(r), 32'(c) ^ s};
    endfunction

    task automatic chk_reset(input string t);
        chk({t, "_cmd_ready"}, TW'(cmd_ready), TW'(1));
        chk({t, "_ctrl"}, TW'({fetch_req, eng_start, out_valid,
                               out_last, busy, layer_done}), TW'(0));
        chk({t, "_coords"}, TW'({fetch_row, fetch_col, out_row, out_col}),
            TW'(0));
        chk({t, "_cfg"}, TW'({eng_enable_bias, eng_enable_relu,
                              eng_enable_requant, eng_shift}), TW'(0));
        chk({t, "_data"}, out_data, TW'(0));
    endtask

    task automatic step();
        bit hs;
        @(negedge clk);
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done   = 1'b1;
                eng_result = tile_val(seed, eng_r, eng_c);
            end
        end
        fetch_ack = 1'b0;
        if (fetch_req) begin
            if (ack_wait >= ackd) begin
                fetch_ack = 1'b1;
                ack_wait  = 0;
                ack_r     = int'(fetch_row);
                ack_c     = int'(fetch_col);
            end else begin
                ack_wait++;
            end
        end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
        end
        cmd_valid = cmd_pend;
        if (!cmd_pend) begin
            cmd_valid          = spur && busy && ($urandom_range(3) == 0);
            cmd_m_tiles        = IW'($urandom);
            cmd_n_tiles        = IW'($urandom);
            cmd_shift          = 5'($urandom);
            cmd_enable_bias    = 1'($urandom);
            cmd_enable_relu    = 1'($urandom);
            cmd_enable_requant = 1'($urandom);
        end
        #1;
        chk("start_after_ack", TW'(eng_start), TW'(ack_prev));
        chk("busy_vs_ready", TW'(busy), TW'(!cmd_ready));
        if (acc_prev) begin
            chk("accept_ready_low", TW'(cmd_ready), TW'(0));
            if (ntiles == 0) chk("zero_done", TW'(layer_done), TW'(1));
            else             chk("accept_fetch", TW'(fetch_req), TW'(1));
        end
        if (prev_cap) begin
            chk("cap_valid", TW'(out_valid), TW'(1));
            if (cap_cnt < ntiles) chk("cap_next_fetch", TW'(fetch_req), TW'(1));
            else                  chk("cap_last_nofetch", TW'(fetch_req), TW'(0));
        end
        if (ntiles == 0) chk("zero_no_valid", TW'(out_valid), TW'(0));
        if (cfg_valid && busy)
            chk("cfg_hold", TW'({eng_enable_bias, eng_enable_relu,
                                 eng_enable_requant, eng_shift}),
                TW'(cfg_word));
        if (fetch_req) begin
            if (fetch_idx < exp_q.size()) begin
                chk("fetch_row", TW'(fetch_row), TW'(exp_q[fetch_idx].r));
                chk("fetch_col", TW'(fetch_col), TW'(exp_q[fetch_idx].c));
            end else begin
                chk("extra_fetch", TW'(fetch_req), TW'(0));
            end
        end
        if (fetch_ack) fetch_idx++;
        if (eng_start) begin
            chk("start_engine_idle", TW'(eng_cnt), TW'(0));
            starts++;
            chk("start_backlog", TW'(starts - hs_cnt <= 2), TW'(1));
            eng_cnt = lat;
            eng_r   = ack_r;
            eng_c   = ack_c;
        end
        if (prev_stall) begin
            chk("stall_data", out_data, prev_data);
        end
        hs = out_valid && out_ready;
        if (hs) begin
            if (out_idx < exp_q.size()) begin
                chk("out_row", TW'(out_row), TW'(exp_q[out_idx].r));
                chk("out_col", TW'(out_col), TW'(exp_q[out_idx].c));
                chk("out_last", TW'(out_last), TW'(exp_q[out_idx].last));
                chk("out_data", out_data,
                    tile_val(seed, exp_q[out_idx].r, exp_q[out_idx].c));
            end else begin
                chk("extra_tile", TW'(hs), TW'(0));
            end
            out_idx++;
            hs_cnt++;
            if (out_last) chk("done_with_last", TW'(layer_done), TW'(1));
        end
        if (layer_done) begin
            chk("done_all_out", TW'(out_idx), TW'(ntiles));
            done_seen = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_cap   = eng_done && (!out_valid || out_ready);
        if (prev_cap) cap_cnt++;
        acc_prev = cmd_valid && cmd_ready;
        if (acc_prev) begin
            cmd_pend  = 1'b0;
            cfg_valid = 1'b1;
        end
        ack_prev = fetch_ack;
    endtask

    task automatic start_layer(input int m, input int n, input int sh,
                               input bit b, input bit rl, input bit rq,
                               input int ad, input int lt, input int rp,
                               input int st, input bit sp);
        exp_q.delete();
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++)
                exp_q.push_back('{r: r, c: c,
                                  last: (r == m - 1 && c == n - 1)});
        ntiles = m * n;
        fetch_idx = 0; out_idx = 0; cap_cnt = 0; starts = 0; hs_cnt = 0;
        ackd = ad; lat = lt; rdy_pct = rp; stall_left = st; spur = sp;
        ack_wait = 0; done_seen = 1'b0; cfg_valid = 1'b0;
        seed = $urandom;
        cfg_word           = {b, rl, rq, 5'(sh)};
        cmd_m_tiles        = IW'(m);
        cmd_n_tiles        = IW'(n);
        cmd_shift          = 5'(sh);
        cmd_enable_bias    = b;
        cmd_enable_relu    = rl;
        cmd_enable_requant = rq;
        cmd_pend           = 1'b1;
        step();
        chk("cmd_taken", TW'(acc_prev), TW'(1));
    endtask

    task automatic run_layer(input int m, input int n, input int sh,
                             input bit b, input bit rl, input bit rq,
                             input int ad, input int lt, input int rp,
                             input int st, input bit sp);
        int budget, cyc;
        start_layer(m, n, sh, b, rl, rq, ad, lt, rp, st, sp);
        budget = 100 + st + ntiles * (ad + lt + 12);
        cyc = 0;
        while (!done_seen && cyc < budget) begin
            step();
            cyc++;
        end
        chk("layer_done_seen", TW'(done_seen), TW'(1));
        chk("tiles_delivered", TW'(out_idx), TW'(ntiles));
        chk("tiles_fetched", TW'(fetch_idx), TW'(ntiles));
        step();
        chk("idle_after_done", TW'(cmd_ready), TW'(1));
        chk("done_one_pulse", TW'(layer_done), TW'(0));
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_m_tiles = '0; cmd_n_tiles = '0;
        cmd_enable_bias = 1'b0; cmd_enable_relu = 1'b0;
        cmd_enable_requant = 1'b0; cmd_shift = '0;
        fetch_ack = 1'b0; eng_done = 1'b0; eng_result = '0;
        out_ready = 1'b0;
        eng_cnt = 0; ntiles = 1; spur = 1'b0; cmd_pend = 1'b0;
        ack_prev = 1'b0; prev_cap = 1'b0; acc_prev = 1'b0;
        prev_stall = 1'b0; cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;

        run_layer(2, 3, 7, 1, 1, 1, 0, 4, 100, 0, 0);
        run_layer(1, 2, 3, 0, 1, 0, 0, 3, 100, 50, 0);
        run_layer(2, 2, 9, 1, 0, 1, 5, 2, 100, 0, 0);
        run_layer(0, 4, 1, 0, 0, 0, 0, 2, 100, 0, 0);
        run_layer(3, 0, 2, 1, 1, 1, 0, 2, 100, 0, 0);
        run_layer(2, 2, 7, 1, 0, 1, 1, 3, 70, 0, 1);

        // Reset while the engine runs tile 1 and tile 0 sits unconsumed.
        start_layer(2, 2, 4, 1, 1, 0, 0, 6, 0, 1000, 0);
        cyc = 0;
        while (!(out_valid && eng_cnt > 0 && !eng_start) && cyc < 200) begin
            step();
            cyc++;
        end
        chk("reach_wait_valid", TW'(out_valid && eng_cnt > 0), TW'(1));
        #2 rst = 1'b1;
        #1 chk_reset("async_rst");
        @(negedge clk);
        chk_reset("rst_held");
        eng_cnt = 0; ack_prev = 1'b0; prev_cap = 1'b0; acc_prev = 1'b0;
        prev_stall = 1'b0; cfg_valid = 1'b0; stall_left = 0;
        fetch_ack = 1'b0; eng_done = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        run_layer(1, 1, 12, 0, 1, 1, 0, 3, 100, 0, 0);

        run_layer(1, 255, 5, 1, 0, 0, 0, 1, 100, 0, 0);

        for (int i = 0; i < 10; i++) begin
            run_layer($urandom_range(3), $urandom_range(3),
                      $urandom_range(31), 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(3), $urandom_range(1, 5),
                      $urandom_range(30, 100), $urandom_range(0, 10), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
